// File: rtl/gcd_engine.sv
// GCD unit computing gcd(a_in, b_in) by repeated subtraction behind a
// start/busy/done handshake, with zero-operand detection and a saturating step count.
module gcd_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero_err,
  output logic [CNT_W-1:0] iter_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] ITER_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] ITER_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_err_q, zero_err_d;
  logic [CNT_W-1:0] iter_q, iter_d;

  logic a_eq_b;
  logic a_gt_b;
  logic a_in_zero;
  logic b_in_zero;

  // One comparator pair on the operand registers serves both the stop test and the step direction.
  assign a_eq_b    = (a_q == b_q);
  assign a_gt_b    = (a_q > b_q);
  assign a_in_zero = (a_in == '0);
  assign b_in_zero = (b_in == '0);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    zero_err_d = zero_err_q;
    iter_d     = iter_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d        = a_in;
          b_d        = b_in;
          iter_d     = '0;
          zero_err_d = 1'b0;
          if (a_in_zero || b_in_zero) begin
            result_d   = a_in | b_in;
            zero_err_d = a_in_zero && b_in_zero;
            state_d    = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (a_eq_b) begin
          result_d = a_q;
          state_d  = S_DONE;
        end else begin
          if (a_gt_b) begin
            a_d = a_q - b_q;
          end else begin
            b_d = b_q - a_q;
          end
          if (iter_q != ITER_MAX) begin
            iter_d = iter_q + ITER_ONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      zero_err_q <= 1'b0;
      iter_q     <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      zero_err_q <= zero_err_d;
      iter_q     <= iter_d;
    end
  end

  // Status flags are decoded from the state register only, so they carry no input-to-output path.
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign result     = result_q;
  assign zero_err   = zero_err_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: directed cases plus random operands
// compared against a Euclid-division reference model.
module tb_gcd_engine;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] aIn;
   logic [7:0] bIn;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       zeroErr;
   logic [7:0] iterCount;

   int checkCount;
   int errorCount;

   gcd_engine #(.WIDTH(8), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a_in      (aIn),
      .b_in      (bIn),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .zero_err  (zeroErr),
      .iter_count(iterCount)
   );

   // Free-running clock with a 10-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input int unsigned got, input int unsigned exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: Euclid by division. Each quotient q means q subtractions,
   // except the final step stops at equality, so one fewer is performed overall.
   function automatic void refModel(input int unsigned a, input int unsigned b,
                                    output int unsigned g, output int unsigned n,
                                    output bit z);
      int unsigned x;
      int unsigned y;
      int unsigned r;
      z = (a == 0) && (b == 0);
      n = 0;
      if (a == 0 || b == 0) begin
         g = a | b;
      end else begin
         x = a;
         y = b;
         while (y != 0) begin
            n += x / y;
            r = x % y;
            x = y;
            y = r;
         end
         g = x;
         n = n - 1;
         if (n > 255) n = 255;
      end
   endfunction

   // Launch one computation, wait for done, check latency/busy/outputs,
   // then confirm done was a single pulse and the outputs hold afterwards.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                input bit inject, input string tag);
      int unsigned g;
      int unsigned n;
      bit          z;
      int          cycles;
      int          busyCycles;
      int          extraDone;
      int unsigned expLat;
      refModel(a, b, g, n, z);
      expLat = (a == 0 || b == 0) ? 0 : n + 1;

      @(negedge clk);
      aIn   = a;
      bIn   = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start      = 1'b0;
      cycles     = 0;
      busyCycles = 0;
      while (!done && cycles < 400) begin
         if (busy) busyCycles++;
         if (inject && cycles == 1) begin
            aIn   = 8'd5;
            bIn   = 8'd3;
            start = 1'b1;
         end else if (inject && cycles == 2) begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         cycles++;
      end
      start = 1'b0;

      checkOutput($sformatf("%s.latency", tag), cycles, expLat);
      checkOutput($sformatf("%s.busyCycles", tag), busyCycles, expLat);
      checkOutput($sformatf("%s.result", tag), result, g);
      checkOutput($sformatf("%s.zeroErr", tag), zeroErr, z);
      checkOutput($sformatf("%s.iterCount", tag), iterCount, n);

      extraDone = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (done) extraDone++;
      end
      checkOutput($sformatf("%s.extraDone", tag), extraDone, 0);
      checkOutput($sformatf("%s.heldResult", tag), result, g);
      checkOutput($sformatf("%s.heldIter", tag), iterCount, n);
   endtask

   // Directed sequence, reset-abort case, back-to-back case, then random operands.
   initial begin
      int          pulses;
      int          lastDone;
      int          t;
      int          neverDone;
      logic [7:0]  ra;
      logic [7:0]  rb;

      checkCount = 0;
      errorCount = 0;
      rst   = 1'b1;
      start = 1'b0;
      aIn   = '0;
      bIn   = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset.busy", busy, 0);
      checkOutput("reset.done", done, 0);
      checkOutput("reset.result", result, 0);
      checkOutput("reset.zeroErr", zeroErr, 0);
      checkOutput("reset.iterCount", iterCount, 0);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(8'd12,  8'd8,  1'b0, "a12b8");
      applyStimulus(8'd0,   8'd9,  1'b0, "a0b9");
      applyStimulus(8'd0,   8'd0,  1'b0, "a0b0");
      applyStimulus(8'd7,   8'd7,  1'b0, "a7b7");
      applyStimulus(8'd255, 8'd1,  1'b0, "a255b1");
      applyStimulus(8'd48,  8'd18, 1'b1, "a48b18ign");

      // Abort a long computation with reset at E0+10.
      @(negedge clk);
      aIn   = 8'd200;
      bIn   = 8'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("abort.busy", busy, 0);
      checkOutput("abort.done", done, 0);
      checkOutput("abort.result", result, 0);
      checkOutput("abort.zeroErr", zeroErr, 0);
      checkOutput("abort.iterCount", iterCount, 0);
      neverDone = 0;
      repeat (100) begin
         @(posedge clk);
         #1;
         if (done || busy) neverDone++;
      end
      checkOutput("abort.quiet", neverDone, 0);
      applyStimulus(8'd9, 8'd6, 1'b0, "a9b6");

      // Start held high: a result of 2 every five cycles, stable in between.
      @(negedge clk);
      aIn   = 8'd6;
      bIn   = 8'd4;
      start = 1'b1;
      pulses   = 0;
      lastDone = -1;
      t        = 0;
      while (pulses < 4 && t < 60) begin
         @(posedge clk);
         #1;
         t++;
         if (pulses > 0) checkOutput("held.stable", result, 2);
         if (done) begin
            checkOutput("held.result", result, 2);
            if (lastDone >= 0) checkOutput("held.period", t - lastDone, 5);
            lastDone = t;
            pulses++;
         end
      end
      checkOutput("held.pulses", pulses, 4);
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(posedge clk);

      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) ra = 8'd0;
         if ($urandom_range(0, 7) == 0) rb = 8'd0;
         applyStimulus(ra, rb, 1'b0, $sformatf("rand%0d_a%0d_b%0d", i, ra, rb));
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/gcd_engine.md
Name: gcd_engine

Overview:
- Parametrised, self-contained GCD unit: controller FSM plus operand datapath in one block.
- Computes the GCD of two unsigned WIDTH-bit operands by repeated subtraction.
- Uses a start/busy/done handshake and reports the subtraction count.
- Adds behaviour the first-generation controller lacks: explicit zero-operand handling, a busy indication, ignored restart while busy, and synchronous reset.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range 2..32.
- CNT_W, WIDTH: width of iter_count; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  operand A; captured on the accepting edge.
- b_in  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  GCD; held until the next accepted start or rst.
- zero_err  output  1  set when both operands are 0; held with result.
- iter_count  output  CNT_W  subtraction steps performed; held with result.

Behaviour:
- Reset values: rst sampled high at an edge forces the following.
  - State IDLE.
  - busy=0, done=0, result=0, zero_err=0, iter_count=0.
  - Internal A/B registers = 0.
- Reset takes priority over every other event, including mid-RUN and in DONE. An in-flight computation is discarded with no done pulse.
- States: IDLE, RUN, DONE. Encoding is free; there is no unreachable-state lockup, and any illegal state goes to IDLE on the next edge.
- IDLE:
  - On an edge with start=1, capture A<=a_in, B<=b_in.
  - Clear iter_count and zero_err.
  - If a_in==0 or b_in==0:
    - result <= a_in|b_in.
    - zero_err <= (a_in==0 && b_in==0).
    - Go to DONE.
  - Otherwise go to RUN.
  - With start=0, remain in IDLE; outputs hold.
- RUN: one comparison/subtraction per edge.
  - A==B: result<=A, go to DONE.
  - A>B: A<=A-B, iter_count++.
  - A<B: B<=B-A, iter_count++.
  - A and B are never 0 in RUN, so the subtraction never underflows.
  - iter_count saturates at its maximum and never wraps.
- DONE:
  - done=1 for exactly this one cycle.
  - Unconditionally go to IDLE on the next edge.
  - start is ignored in DONE.
- Outputs busy, done and zero_err are decoded or registered so that they are glitch-free. There are no combinational paths from inputs to outputs.
- Latency: let E0 be the accepting edge and n the number of subtractions.
  - Nonzero operands: done is high in the cycle after edge E0+n+1.
  - Zero operand: done is high in the cycle after E0.
- start during RUN or DONE is ignored. There is no queuing, and a_in/b_in changes are not observed.
- start held high continuously: a new computation is accepted in each IDLE cycle. Back-to-back throughput is one result per n+3 cycles.
- result, zero_err and iter_count stay stable from DONE until the next accepting edge. They update on that edge, or on the zero path at E0.
- Arithmetic: unsigned, WIDTH bits. The equality/magnitude comparison is a single shared comparator.
- No # delays and no latches. All state updates are nonblocking on posedge clk.

Test Plan:
- WIDTH=8, start with a=12, b=8 -> A/B sequence (4,8),(4,4). done is high after E0+3, result=4, iter_count=2, zero_err=0, busy high for 3 cycles.
- a=0, b=9 -> done after E0, result=9, iter_count=0, zero_err=0. Then a=0, b=0 -> result=0, zero_err=1.
- a=7, b=7 -> done after E0+1, result=7, iter_count=0. a=255, b=1 -> result=1, iter_count=254, done after E0+255.
- Start a=48, b=18 (expected result 6). Pulse start with a=5, b=3 during RUN -> ignored; result=6, iter_count=4, exactly one done pulse.
- Start a=200, b=3, then assert rst for one edge at E0+10 -> busy=0, done never pulses, all outputs 0. A subsequent start with a=9, b=6 -> result=3.
- start held high with a=6, b=4 -> results of 2 with done pulses every 5 cycles. result stays stable between pulses.
